reduce_pipe: RTL

Multi-channel, handshaked bit-reduction unit: the parametrised, sequential successor to the toplevel's combinational `&xa` / `~&xb` reductions. It accepts one word per channel and reduces each word to a single bit with a run-time selected operator (AND / OR / XOR / all-equal, optionally inverted). It consumes CHUNK bits per cycle, trading latency for area, and returns one result bit per channel through a valid/ready output port. It sits between the operand registers and any downstream consumer that needs flag-style results.

---
 rtl/reduce_pkg.sv | 35 +++
 rtl/reduce_lane.sv | 86 ++++++++
 rtl/reduce_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
// Shared types and helpers for the reduce_pipe bit-reduction unit.
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_EQ  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ACC_AND = 2'd0,
    ACC_OR  = 2'd1,
    ACC_XOR = 2'd2
  } acc_e;

  // Value that leaves an accumulator of the given kind unchanged when folded in.
  function automatic logic acc_identity(input acc_e kind);
    logic id_v;
    case (kind)
      ACC_AND: id_v = 1'b1;
      ACC_OR:  id_v = 1'b0;
      ACC_XOR: id_v = 1'b0;
      default: id_v = 1'b0;
    endcase
    return id_v;
  endfunction

endpackage

// File: rtl/reduce_lane.sv
// One reduction lane: folds CHUNK bits per beat into AND/OR/XOR accumulators
// and presents the operator-selected, optionally inverted result of the fold.
module reduce_lane
  import reduce_pkg::*;
#(
  parameter int WIDTH  = 11,
  parameter int CHUNK  = 4,
  parameter int NBEATS = 3,
  parameter int BEAT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              fold,
  input  logic [BEAT_W-1:0] beat,
  input  logic [WIDTH-1:0]  data,
  input  op_e               op,
  input  logic              inv,
  output logic              result
);

  localparam int PADW = NBEATS * CHUNK - WIDTH;

  logic [NBEATS*CHUNK-1:0] and_word_s;
  logic [NBEATS*CHUNK-1:0] or_word_s;
  logic [CHUNK-1:0]        and_chunk_s;
  logic [CHUNK-1:0]        or_chunk_s;
  logic                    and_acc_r;
  logic                    or_acc_r;
  logic                    xor_acc_r;
  logic                    and_next_s;
  logic                    or_next_s;
  logic                    xor_next_s;
  logic                    sel_s;

  // Bits past WIDTH-1 in the last chunk carry the identity so they never matter.
  generate
    if (PADW > 32'sd0) begin : g_pad
      assign and_word_s = {{PADW{acc_identity(ACC_AND)}}, data};
      assign or_word_s  = {{PADW{acc_identity(ACC_OR)}}, data};
    end else begin : g_nopad
      assign and_word_s = data;
      assign or_word_s  = data;
    end
  endgenerate

  // Chunk extraction, fold and result selection for the current beat.
  always_comb begin
    and_chunk_s = CHUNK'(and_word_s >> (beat * CHUNK));
    or_chunk_s  = CHUNK'(or_word_s >> (beat * CHUNK));
    and_next_s  = and_acc_r & (&and_chunk_s);
    or_next_s   = or_acc_r | (|or_chunk_s);
    xor_next_s  = xor_acc_r ^ (^or_chunk_s);
    sel_s       = and_next_s;
    case (op)
      OP_AND:  sel_s = and_next_s;
      OP_OR:   sel_s = or_next_s;
      OP_XOR:  sel_s = xor_next_s;
      OP_EQ:   sel_s = and_next_s | ~or_next_s;
      default: sel_s = and_next_s;
    endcase
    result = sel_s ^ inv;
  end

  // Accumulator registers: identity on accept, fold while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_acc_r <= 1'b0;
      or_acc_r  <= 1'b0;
      xor_acc_r <= 1'b0;
    end else if (load) begin
      and_acc_r <= acc_identity(ACC_AND);
      or_acc_r  <= acc_identity(ACC_OR);
      xor_acc_r <= acc_identity(ACC_XOR);
    end else if (fold) begin
      and_acc_r <= and_next_s;
      or_acc_r  <= or_next_s;
      xor_acc_r <= xor_next_s;
    end else begin
      and_acc_r <= and_acc_r;
      or_acc_r  <= or_acc_r;
      xor_acc_r <= xor_acc_r;
    end
  end

endmodule

// File: rtl/reduce_pipe.sv
// Multi-channel handshaked bit reducer: owns the IDLE/BUSY/DONE FSM, beat
// counter, operand latches and the registered result port.
module reduce_pipe
  import reduce_pkg::*;
#(
  parameter int WIDTH    = 11,
  parameter int CHANNELS = 2,
  parameter int CHUNK    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic                      in_inv,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_data
);

  localparam int NBEATS = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int BEAT_W = $clog2(NBEATS) + 1;

  state_e                    state_r;
  state_e                    state_nx_s;
  logic [BEAT_W-1:0]         beat_r;
  op_e                       op_r;
  logic                      inv_r;
  logic [CHANNELS*WIDTH-1:0] data_r;
  logic                      out_valid_r;
  logic [CHANNELS-1:0]       out_data_r;
  logic [CHANNELS-1:0]       lane_res_s;
  logic                      accept_s;
  logic                      fold_s;
  logic                      last_s;

  // Ready in DONE only when the pending result is being taken this same edge.
  assign in_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign fold_s    = (state_r == ST_BUSY);
  assign last_s    = (beat_r == BEAT_W'(NBEATS - 1));
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_BUSY;
        else          state_nx_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (last_s) state_nx_s = ST_DONE;
        else        state_nx_s = ST_BUSY;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) state_nx_s = ST_BUSY;
          else          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Operand latches and beat counter; the counter parks at NBEATS in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= OP_AND;
      inv_r  <= 1'b0;
      data_r <= {(CHANNELS*WIDTH){1'b0}};
      beat_r <= {BEAT_W{1'b0}};
    end else if (accept_s) begin
      op_r   <= op_e'(in_op);
      inv_r  <= in_inv;
      data_r <= in_data;
      beat_r <= {BEAT_W{1'b0}};
    end else if (fold_s) begin
      op_r   <= op_r;
      inv_r  <= inv_r;
      data_r <= data_r;
      beat_r <= beat_r + BEAT_W'(1'b1);
    end else begin
      op_r   <= op_r;
      inv_r  <= inv_r;
      data_r <= data_r;
      beat_r <= beat_r;
    end
  end

  // Result port: captured on the final fold, held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {CHANNELS{1'b0}};
    end else if (fold_s && last_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= lane_res_s;
    end else if ((state_r == ST_DONE) && out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      reduce_lane #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .NBEATS(NBEATS),
        .BEAT_W(BEAT_W)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_s),
        .fold  (fold_s),
        .beat  (beat_r),
        .data  (data_r[i*WIDTH +: WIDTH]),
        .op    (op_r),
        .inv   (inv_r),
        .result(lane_res_s[i])
      );
    end
  endgenerate

endmodule
